id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register combined with load-use hazard detection and pipeline hold/flush control for the 5-stage RV32 pipeline. It captures decoded ID-stage operands and control, and drives the EX-stage rs1/rs2 indices consumed by the forwarding unit. It generates the stall that freezes PC and IF/ID, and inserts bubbles on load-use hazards and on flushes. It also keeps a saturating bubble-count performance counter.

Parameters:
DATA_W, 32, operand/PC/immediate width
REG_AW, 5, register index width
CNT_W, 16, bubble counter width

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
id_valid_i  in  1  ID holds a real instruction
id_rs1_i  in  REG_AW  source 1 index
id_rs2_i  in  REG_AW  source 2 index
id_rd_i  in  REG_AW  destination index
id_use_rs1_i  in  1  instruction reads rs1
id_use_rs2_i  in  1  instruction reads rs2
id_rs1_data_i  in  DATA_W  regfile read 1
id_rs2_data_i  in  DATA_W  regfile read 2
id_imm_i  in  DATA_W  immediate
id_pc_i  in  DATA_W  PC
id_funct_i  in  4  {instr[30], instr[14:12]}
id_wb_ctrl_i  in  3  [2]=RegWrite, [1]=MemtoReg, [0]=reserved
id_mem_ctrl_i  in  2  [1]=MemRead, [0]=MemWrite
id_ex_ctrl_i  in  4  [3]=ALUSrc, [2:1]=ALUOp, [0]=Branch
flush_i  in  1  taken branch/jump resolved downstream
ex_busy_i  in  1  EX unit needs the current EX instruction held
stall_o  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid_o  out  1  EX-stage valid
ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_AW each  EX-stage indices (to forwarding unit)
ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  out  DATA_W each  EX operands
ex_funct_o  out  4  EX funct
ex_wb_ctrl_o  out  3  EX WB control
ex_mem_ctrl_o  out  2  EX MEM control
ex_ex_ctrl_o  out  4  EX EX control
bubble_cnt_o  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_i high at a rising edge): all registered outputs go to 0, including bubble_cnt_o. While rst_i is high, stall_o = 0. Reset overrides every other input.
- A hazard condition is true when all of the following hold:
  - ex_valid_o and ex_mem_ctrl_o[1] are set;
  - ex_rd_o != 0;
  - id_valid_i is set;
  - (id_use_rs1_i and id_rs1_i == ex_rd_o) or (id_use_rs2_i and id_rs2_i == ex_rd_o).
- Each cycle the stage is in one of four modes, strict priority:
  - FLUSH (flush_i=1): load a bubble. stall_o = 0. flush_i overrides ex_busy_i and the hazard.
  - HOLD (ex_busy_i=1): all EX registers keep their values. stall_o = 1.
  - BUBBLE (hazard true): load a bubble. stall_o = 1, so the ID instruction is re-presented next cycle.
  - PASS: load all id_* fields, ex_valid_o <= id_valid_i. stall_o = 0.
- A bubble sets ex_valid_o, ex_wb_ctrl_o, ex_mem_ctrl_o and ex_ex_ctrl_o to 0, and sets ex_rd_o, ex_rs1_o and ex_rs2_o to 0 so no false forwarding can occur. Data fields may keep stale values.
- Latency: 1 cycle from ID to EX. A load-use hazard inserts exactly one bubble; on the next cycle the load is in MEM and the hazard clears naturally.
- bubble_cnt_o increments by 1 on every FLUSH or BUBBLE cycle and saturates at all-ones.
- A bubble following a bubble is harmless: ex_valid_o = 0 blocks a repeat hazard.
- x0 is never treated as a hazard.
- If flush_i and reset occur in the same cycle, reset wins.

Decomposition:
- Shared package pipe_pkg holds:
  - control bit-position constants (WB_REGWRITE=2, WB_MEMTOREG=1, MEM_READ=1, MEM_WRITE=0, EX_ALUSRC=3, EX_BRANCH=0);
  - control-field widths (3/2/4);
  - mode encoding (PASS, HOLD, BUBBLE, FLUSH).
- One natural sub-module: load_use_detect, a purely combinational hazard compare. It is instantiated once.

Test Plan:
- Reset: rst_i=1 for 2 cycles with random id_* values -> all outputs 0 and stall_o=0; after release, the first PASS loads id_*.
- Load-use: EX holds lw x5 (mem_ctrl=2'b10, rd=5, valid); ID holds add x6,x5,x7 (rs1=5, use_rs1=1) -> stall_o=1, next-cycle ex_valid_o=0 and controls 0, bubble_cnt_o=1; the following cycle add enters EX with ex_rs1_o=5.
- No hazard: lw into x0, or ID rs2=5 with id_use_rs2_i=0 -> stall_o=0 and ID passes through.
- Flush overrides: hazard true together with flush_i=1 -> stall_o=0, bubble loaded, bubble_cnt_o increments.
- Hold: ex_busy_i=1 for 3 cycles -> stall_o=1 and EX outputs unchanged every cycle; on release the ID instruction loads.
- Saturation: preload the counter via 2^CNT_W+2 bubbles (or reduce CNT_W=4: 18 bubbles) -> bubble_cnt_o stays at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bit positions, control-field widths,
// ID/EX control payload and the stage-mode encoding.
package pipe_pkg;

   localparam int unsigned WB_W  = 3;
   localparam int unsigned MEM_W = 2;
   localparam int unsigned EXC_W = 4;

   localparam int unsigned WB_REGWRITE = 2;
   localparam int unsigned WB_MEMTOREG = 1;
   localparam int unsigned MEM_READ    = 1;
   localparam int unsigned MEM_WRITE   = 0;
   localparam int unsigned EX_ALUSRC   = 3;
   localparam int unsigned EX_BRANCH   = 0;

   typedef struct packed {
      logic [WB_W-1:0]  wb;
      logic [MEM_W-1:0] mem;
      logic [EXC_W-1:0] ex;
   } ctrl_t;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_HOLD   = 2'd1,
      MODE_BUBBLE = 2'd2,
      MODE_FLUSH  = 2'd3
   } mode_e;

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// ID-to-EX bundle: decoded ID fields and pipeline control in, EX-stage fields out.
interface id_ex_hazard_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
);
   logic              id_valid_i;
   logic [REG_AW-1:0] id_rs1_i;
   logic [REG_AW-1:0] id_rs2_i;
   logic [REG_AW-1:0] id_rd_i;
   logic              id_use_rs1_i;
   logic              id_use_rs2_i;
   logic [DATA_W-1:0] id_rs1_data_i;
   logic [DATA_W-1:0] id_rs2_data_i;
   logic [DATA_W-1:0] id_imm_i;
   logic [DATA_W-1:0] id_pc_i;
   logic [3:0]        id_funct_i;
   logic [2:0]        id_wb_ctrl_i;
   logic [1:0]        id_mem_ctrl_i;
   logic [3:0]        id_ex_ctrl_i;
   logic              flush_i;
   logic              ex_busy_i;

   logic              stall_o;
   logic              ex_valid_o;
   logic [REG_AW-1:0] ex_rs1_o;
   logic [REG_AW-1:0] ex_rs2_o;
   logic [REG_AW-1:0] ex_rd_o;
   logic [DATA_W-1:0] ex_rs1_data_o;
   logic [DATA_W-1:0] ex_rs2_data_o;
   logic [DATA_W-1:0] ex_imm_o;
   logic [DATA_W-1:0] ex_pc_o;
   logic [3:0]        ex_funct_o;
   logic [2:0]        ex_wb_ctrl_o;
   logic [1:0]        ex_mem_ctrl_o;
   logic [3:0]        ex_ex_ctrl_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
             id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i, id_funct_i,
             id_wb_ctrl_i, id_mem_ctrl_i, id_ex_ctrl_i, flush_i, ex_busy_i,
      input  stall_o, ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o,
             ex_rs2_data_o, ex_imm_o, ex_pc_o, ex_funct_o, ex_wb_ctrl_o,
             ex_mem_ctrl_o, ex_ex_ctrl_o, bubble_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i,
             id_rs1_data_i, id_rs2_data_i, id_imm_i, id_pc_i, id_funct_i,
             id_wb_ctrl_i, id_mem_ctrl_i, id_ex_ctrl_i, flush_i, ex_busy_i,
      output stall_o, ex_valid_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o,
             ex_rs2_data_o, ex_imm_o, ex_pc_o, ex_funct_o, ex_wb_ctrl_o,
             ex_mem_ctrl_o, ex_ex_ctrl_o, bubble_cnt_o
   );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the sources read in ID.
module load_use_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   output logic              hazard_o
);
   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 never carries a loaded value, so it can never be a hazard
   assign hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                     id_valid_i && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall, hold/flush bubble insertion
// and a saturating bubble counter.
module id_ex_hazard_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input logic                clk_i,
   input logic                rst_i,
   id_ex_hazard_stage_if.slave bus
);
   logic              hazard;
   mode_e             mode_c;

   logic              valid_q, valid_d;
   logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [DATA_W-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [DATA_W-1:0] imm_q, imm_d, pc_q, pc_d;
   logic [3:0]        funct_q, funct_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   load_use_detect #(.REG_AW(REG_AW)) u_detect (
      .ex_valid_i    (valid_q),
      .ex_mem_read_i (ctrl_q.mem[MEM_READ]),
      .ex_rd_i       (rd_q),
      .id_valid_i    (bus.id_valid_i),
      .id_rs1_i      (bus.id_rs1_i),
      .id_rs2_i      (bus.id_rs2_i),
      .id_use_rs1_i  (bus.id_use_rs1_i),
      .id_use_rs2_i  (bus.id_use_rs2_i),
      .hazard_o      (hazard)
   );

   // Strict priority: flush, then EX hold, then load-use bubble
   always_comb begin
      mode_c = MODE_PASS;
      if (bus.flush_i)        mode_c = MODE_FLUSH;
      else if (bus.ex_busy_i) mode_c = MODE_HOLD;
      else if (hazard)        mode_c = MODE_BUBBLE;
   end

   assign bus.stall_o = !rst_i && ((mode_c == MODE_HOLD) || (mode_c == MODE_BUBBLE));

   always_comb begin
      valid_d    = valid_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      pc_d       = pc_q;
      funct_d    = funct_q;
      ctrl_d     = ctrl_q;
      cnt_d      = cnt_q;
      case (mode_c)
         MODE_PASS: begin
            valid_d    = bus.id_valid_i;
            rs1_d      = bus.id_rs1_i;
            rs2_d      = bus.id_rs2_i;
            rd_d       = bus.id_rd_i;
            rs1_data_d = bus.id_rs1_data_i;
            rs2_data_d = bus.id_rs2_data_i;
            imm_d      = bus.id_imm_i;
            pc_d       = bus.id_pc_i;
            funct_d    = bus.id_funct_i;
            ctrl_d     = '{wb: bus.id_wb_ctrl_i, mem: bus.id_mem_ctrl_i, ex: bus.id_ex_ctrl_i};
         end
         MODE_BUBBLE, MODE_FLUSH: begin
            // Zeroed indices keep the forwarding unit from matching a bubble
            valid_d = 1'b0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = '0;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         pc_q       <= '0;
         funct_q    <= '0;
         ctrl_q     <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         pc_q       <= pc_d;
         funct_q    <= funct_d;
         ctrl_q     <= ctrl_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.ex_valid_o    = valid_q;
   assign bus.ex_rs1_o      = rs1_q;
   assign bus.ex_rs2_o      = rs2_q;
   assign bus.ex_rd_o       = rd_q;
   assign bus.ex_rs1_data_o = rs1_data_q;
   assign bus.ex_rs2_data_o = rs2_data_q;
   assign bus.ex_imm_o      = imm_q;
   assign bus.ex_pc_o       = pc_q;
   assign bus.ex_funct_o    = funct_q;
   assign bus.ex_wb_ctrl_o  = ctrl_q.wb;
   assign bus.ex_mem_ctrl_o = ctrl_q.mem;
   assign bus.ex_ex_ctrl_o  = ctrl_q.ex;
   assign bus.bubble_cnt_o  = cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: a reference model pushes expected EX
// state into a scoreboard queue each cycle, popped and compared after the edge.
module tb_id_ex_hazard_stage;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 4;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, imm, pc;
      logic [3:0]  funct;
      logic [2:0]  wb;
      logic [1:0]  mem;
      logic [3:0]  exc;
      logic [3:0]  cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err = 0;
   exp_t m = '0;
   exp_t q[$];

   id_ex_hazard_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   id_ex_hazard_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [2:0] wb, input logic [1:0] mem, input logic [3:0] exc);
      bus.id_valid_i    = v;
      bus.id_rs1_i      = r1;
      bus.id_rs2_i      = r2;
      bus.id_rd_i       = rd;
      bus.id_use_rs1_i  = u1;
      bus.id_use_rs2_i  = u2;
      bus.id_wb_ctrl_i  = wb;
      bus.id_mem_ctrl_i = mem;
      bus.id_ex_ctrl_i  = exc;
      bus.id_rs1_data_i = $urandom;
      bus.id_rs2_data_i = $urandom;
      bus.id_imm_i      = $urandom;
      bus.id_pc_i       = $urandom;
      bus.id_funct_i    = 4'($urandom);
   endtask

   task automatic set_rand();
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
             1'($urandom), 3'($urandom), 2'($urandom), 4'($urandom));
   endtask

   // One clock: predict stall and next EX state, then compare after the edge
   task automatic step(input string tag);
      exp_t nx;
      exp_t got;
      logic haz;
      logic exp_stall;
      #1;
      haz = m.valid && m.mem[1] && (m.rd != 5'd0) && bus.id_valid_i &&
            ((bus.id_use_rs1_i && bus.id_rs1_i == m.rd) ||
             (bus.id_use_rs2_i && bus.id_rs2_i == m.rd));
      nx = m;
      exp_stall = 1'b0;
      if (rst) begin
         nx = '0;
      end else if (bus.flush_i || (!bus.ex_busy_i && haz)) begin
         exp_stall = !bus.flush_i;
         nx.valid = 1'b0; nx.rs1 = '0; nx.rs2 = '0; nx.rd = '0;
         nx.wb = '0; nx.mem = '0; nx.exc = '0;
         if (m.cnt != 4'hF) nx.cnt = m.cnt + 4'd1;
      end else if (bus.ex_busy_i) begin
         exp_stall = 1'b1;
      end else begin
         nx.valid = bus.id_valid_i; nx.rs1 = bus.id_rs1_i; nx.rs2 = bus.id_rs2_i;
         nx.rd = bus.id_rd_i; nx.d1 = bus.id_rs1_data_i; nx.d2 = bus.id_rs2_data_i;
         nx.imm = bus.id_imm_i; nx.pc = bus.id_pc_i; nx.funct = bus.id_funct_i;
         nx.wb = bus.id_wb_ctrl_i; nx.mem = bus.id_mem_ctrl_i; nx.exc = bus.id_ex_ctrl_i;
      end
      chk({tag, ".stall"}, 64'(bus.stall_o), 64'(exp_stall));
      q.push_back(nx);
      @(posedge clk);
      #1;
      got = q.pop_front();
      m = got;
      chk({tag, ".valid"}, 64'(bus.ex_valid_o), 64'(got.valid));
      chk({tag, ".idx"}, 64'({bus.ex_rs1_o, bus.ex_rs2_o, bus.ex_rd_o}),
          64'({got.rs1, got.rs2, got.rd}));
      chk({tag, ".ctrl"}, 64'({bus.ex_wb_ctrl_o, bus.ex_mem_ctrl_o, bus.ex_ex_ctrl_o}),
          64'({got.wb, got.mem, got.exc}));
      chk({tag, ".cnt"}, 64'(bus.bubble_cnt_o), 64'(got.cnt));
      if (got.valid || rst) begin
         chk({tag, ".ops"}, {bus.ex_rs1_data_o, bus.ex_rs2_data_o}, {got.d1, got.d2});
         chk({tag, ".immpc"}, {bus.ex_imm_o, bus.ex_pc_o}, {got.imm, got.pc});
         chk({tag, ".funct"}, 64'(bus.ex_funct_o), 64'(got.funct));
      end
   endtask

   initial begin
      bus.flush_i   = 1'b0;
      bus.ex_busy_i = 1'b0;
      set_rand();
      // Reset for two cycles with random ID inputs and a flush
      bus.flush_i = 1'b1;
      step("reset0");
      set_rand();
      step("reset1");
      rst = 1'b0;
      bus.flush_i = 1'b0;
      // lw x5 enters EX
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 3'b110, 2'b10, 4'b1000);
      step("pass_lw");
      // add x6,x5,x7 -> one bubble, then passes
      set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 3'b100, 2'b00, 4'b0100);
      step("loaduse");
      step("loaduse_retry");
      chk("loaduse_rs1", 64'(bus.ex_rs1_o), 64'd5);
      // lw into x0 is never a hazard
      set_id(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 3'b110, 2'b10, 4'b1000);
      step("lw_x0");
      set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 3'b100, 2'b00, 4'b0100);
      step("use_x0");
      // rs2 matches but is not read
      set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 3'b110, 2'b10, 4'b1000);
      step("pass_lw2");
      set_id(1'b1, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, 3'b100, 2'b00, 4'b1100);
      step("rs2_unused");
      // Flush overrides a live hazard
      set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 3'b110, 2'b10, 4'b1000);
      step("pass_lw3");
      set_id(1'b1, 5'd5, 5'd5, 5'd4, 1'b1, 1'b1, 3'b100, 2'b00, 4'b0100);
      bus.flush_i = 1'b1;
      step("flush_haz");
      bus.flush_i = 1'b0;
      // Hold three cycles with changing ID input, then release
      set_id(1'b1, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 3'b100, 2'b01, 4'b0011);
      step("pre_hold");
      bus.ex_busy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_rand();
         step("hold");
      end
      bus.ex_busy_i = 1'b0;
      set_id(1'b1, 5'd13, 5'd14, 5'd15, 1'b0, 1'b1, 3'b100, 2'b00, 4'b0010);
      step("hold_release");
      // Counter saturation through repeated flushes
      bus.flush_i = 1'b1;
      for (int i = 0; i < 18; i++) begin
         set_rand();
         step("saturate");
      end
      chk("sat_final", 64'(bus.bubble_cnt_o), 64'd15);
      // Reset wins over a simultaneous flush
      rst = 1'b1;
      step("rst_flush");
      rst = 1'b0;
      bus.flush_i = 1'b0;
      set_rand();
      step("post_reset");
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
